// File: rtl/tile_sequencer_if.sv
// Host command / array strobe bundle for one systolic tile.
interface tile_sequencer_if;
   logic       start;
   logic [4:0] k_len;
   logic       stall;
   logic       busy;
   logic       load_w;
   logic [4:0] w_row;
   logic       feed_en;
   logic       drain_en;
   logic       done;
   logic [4:0] phase_cnt;

   modport master (
      output start, k_len, stall,
      input  busy, load_w, w_row,
      input  feed_en, drain_en, done, phase_cnt
   );

   modport slave (
      input  start, k_len, stall,
      output busy, load_w, w_row,
      output feed_en, drain_en, done, phase_cnt
   );
endinterface

// File: rtl/tile_sequencer.sv
// Tile phase controller: weight load, operand feed, result drain, done.
// One 5-bit down-counter times every phase.
module tile_sequencer #(
   parameter int DIM = 4
) (
   input  logic             clk,
   input  logic             rst,
   tile_sequencer_if.slave  bus
);
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(DIM - 1);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(2 * DIM - 2);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE, LOAD, FEED, DRAIN, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] klen_q, klen_d;
   logic             last;

   assign last = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         klen_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         klen_q  <= klen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      klen_d  = klen_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               cnt_d   = LOAD_INIT;
               klen_d  = bus.k_len;
            end
         end
         LOAD: begin
            if (!bus.stall) begin
               if (!last) begin
                  cnt_d = cnt_q - ONE;
               end else if (klen_q != '0) begin
                  state_d = FEED;
                  cnt_d   = klen_q - ONE;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_INIT;
               end
            end
         end
         FEED: begin
            if (!bus.stall) begin
               if (!last) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_INIT;
               end
            end
         end
         DRAIN: begin
            if (!bus.stall) begin
               if (!last) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!bus.stall) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // strobes drop during stall; busy and counter views stay live
   assign bus.busy      = (state_q != IDLE);
   assign bus.load_w    = (state_q == LOAD) && !bus.stall;
   assign bus.w_row     = (state_q == LOAD) ? cnt_q : '0;
   assign bus.feed_en   = (state_q == FEED) && !bus.stall;
   assign bus.drain_en  = (state_q == DRAIN) && !bus.stall;
   assign bus.done      = (state_q == DONE) && !bus.stall;
   assign bus.phase_cnt = cnt_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_tile_sequencer;
   localparam int DIM = 4;

   typedef struct packed {
      logic       busy;
      logic       load_w;
      logic [4:0] w_row;
      logic       feed_en;
      logic       drain_en;
      logic       done;
      logic [4:0] phase_cnt;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   int    errors = 0;
   int    checks = 0;
   string tag = "reset";
   exp_t  expq[$];
   exp_t  me, ma;

   always #5 clk = ~clk;

   tile_sequencer_if bus ();

   tile_sequencer #(.DIM(DIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic exp_t mk(input logic b, input logic l,
                               input int row, input logic f,
                               input logic d, input logic dn,
                               input int cnt);
      exp_t e;
      e.busy      = b;
      e.load_w    = l;
      e.w_row     = 5'(row);
      e.feed_en   = f;
      e.drain_en  = d;
      e.done      = dn;
      e.phase_cnt = 5'(cnt);
      return e;
   endfunction

   always @(negedge clk) begin
      if (expq.size() != 0) begin
         me = expq.pop_front();
         ma = {bus.busy, bus.load_w, bus.w_row, bus.feed_en,
               bus.drain_en, bus.done, bus.phase_cnt};
         checks++;
         if (ma !== me) begin
            errors++;
            $display("FAIL %s t=%0t got b%b l%b r%0d f%b d%b dn%b c%0d exp b%b l%b r%0d f%b d%b dn%b c%0d",
                     tag, $time, ma.busy, ma.load_w, ma.w_row,
                     ma.feed_en, ma.drain_en, ma.done, ma.phase_cnt,
                     me.busy, me.load_w, me.w_row, me.feed_en,
                     me.drain_en, me.done, me.phase_cnt);
         end
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.stall = 1'b0;
         rst       = 1'b0;
         expq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   // cycle 0 is the idle cycle where start is presented
   task automatic run(input int k, input int slo, input int shi,
                      input int rcyc, input bit hold);
      exp_t tl[$];
      exp_t e;
      int   p = 0;
      int   c = 0;
      tl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      for (int i = DIM - 1; i >= 0; i--)
         tl.push_back(mk(1, 1, i, 0, 0, 0, i));
      for (int i = k - 1; i >= 0; i--)
         tl.push_back(mk(1, 0, 0, 1, 0, 0, i));
      for (int i = 2 * DIM - 2; i >= 0; i--)
         tl.push_back(mk(1, 0, 0, 0, 1, 0, i));
      tl.push_back(mk(1, 0, 0, 0, 0, 1, 0));
      while (p < tl.size() && c < 200) begin
         @(posedge clk); #1;
         bus.start = (c == 0) || hold;
         bus.k_len = (c == 0) ? 5'(k) : 5'(c * 7 + 1);
         bus.stall = (c >= slo) && (c <= shi);
         rst       = (c == rcyc);
         e = tl[p];
         if (bus.stall && p > 0) begin
            e.load_w   = 1'b0;
            e.feed_en  = 1'b0;
            e.drain_en = 1'b0;
            e.done     = 1'b0;
         end else begin
            p++;
         end
         expq.push_back(e);
         if (c == rcyc) break;
         c++;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.stall = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      expq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      expq.push_back(mk(0, 0, 0, 0, 0, 0, 0));

      tag = "k3_basic";
      run(3, -1, -1, -1, 1'b0);
      idle_cycles(2);

      tag = "k0_skip_feed";
      run(0, 0, 0, -1, 1'b0);
      idle_cycles(1);

      tag = "k3_stall_feed";
      run(3, 6, 7, -1, 1'b0);
      idle_cycles(1);

      tag = "stall_in_done";
      run(0, 12, 12, -1, 1'b0);
      idle_cycles(1);

      tag = "start_held";
      run(2, -1, -1, -1, 1'b1);
      run(2, -1, -1, -1, 1'b1);
      idle_cycles(2);

      tag = "reset_in_feed";
      run(3, -1, -1, 6, 1'b0);
      idle_cycles(2);
      tag = "after_reset";
      run(3, -1, -1, -1, 1'b0);
      idle_cycles(1);

      tag = "k31_max";
      run(31, -1, -1, -1, 1'b0);
      idle_cycles(2);

      @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain_queue left=%0d exp 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Phase controller for one systolic-array tile.
- On a start command it sequences three phases: weight load, operand feed, result drain. It then raises a one-cycle completion pulse.
- Phase lengths are timed by a single 5-bit down-counter, decremented by 1 per active cycle (subtract-one datapath).
- Sits between the host command interface and the array's weight/operand/accumulator enables.

Parameters:
DIM, 4, array dimension (rows = cols); legal 1..16 so that 2*DIM-1 <= 31
CNT_W, 5, phase counter width; fixed at 5

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a tile operation; sampled only in IDLE
k_len  input  5  number of operand vectors to feed (0..31); captured when start is accepted
stall  input  1  freeze sequencing (state and counter hold)
busy  output  1  high in every state except IDLE
load_w  output  1  weight-load strobe to array
w_row  output  5  row index being loaded (counter value during LOAD, else 0)
feed_en  output  1  operand-feed strobe
drain_en  output  1  accumulator-drain strobe
done  output  1  one-cycle completion pulse
phase_cnt  output  5  current counter value (debug/observability)

Behaviour:
- States: IDLE, LOAD, FEED, DRAIN, DONE. Moore outputs, decoded from registered state, counter and stall only.
- Reset (rst=1 at a clock edge):
  - state=IDLE, counter=0, captured k_len=0.
  - All outputs 0.
  - Applies from any state; an operation in progress is abandoned with no done pulse.
- IDLE:
  - start=1 → LOAD, counter=DIM-1, capture k_len. stall is ignored in IDLE.
  - start=0 → remain in IDLE.
- LOAD:
  - load_w=1 and w_row=counter, so rows DIM-1 down to 0 over DIM cycles.
  - At counter==0:
    - k_len_q != 0 → FEED, counter=k_len_q-1.
    - k_len_q == 0 → DRAIN directly, counter=2*DIM-2.
- FEED: feed_en=1 for exactly k_len_q cycles. At counter==0 → DRAIN, counter=2*DIM-2.
- DRAIN: drain_en=1 for exactly 2*DIM-1 cycles. At counter==0 → DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. start in DONE is ignored.
- Counter:
  - When not stalled, decrements by exactly 1 per cycle within a phase.
  - Reloaded on each phase transition.
  - Never wraps below 0: the transition happens at 0.
- stall=1 in LOAD/FEED/DRAIN/DONE:
  - State and counter hold.
  - load_w, feed_en, drain_en and done are forced to 0.
  - busy stays 1; w_row and phase_cnt show the held counter.
  - A stall in DONE delays the done pulse until the stall is released.
- start while busy is ignored entirely; k_len is not re-captured.
- k_len changes after acceptance have no effect.
- Unstalled latency from the start edge (cycle 0) to done: 1 + DIM + k_len + 2*DIM - 1 cycles. done is asserted in that cycle.
- Next accepted start: the cycle after DONE at the earliest.

Test Plan:
1. DIM=4, k_len=3, start pulse at cycle 0, no stall → load_w cycles 1-4 with w_row 3,2,1,0; feed_en cycles 5-7; drain_en cycles 8-14; done only at cycle 15; busy cycles 1-15; IDLE at 16.
2. DIM=4, k_len=0 → load_w cycles 1-4; feed_en never asserted; drain_en cycles 5-11; done at cycle 12.
3. DIM=4, k_len=3, stall high cycles 6-7 → feed_en at 5, 8, 9; strobes 0 during stall; phase_cnt holds 1; drain_en cycles 10-16; done at cycle 17.
4. start held high continuously with k_len=2 → second operation accepted only in the IDLE cycle after DONE; start and k_len changes mid-operation ignored.
5. rst asserted in FEED (cycle 6 of scenario 1) → next cycle all outputs 0, IDLE, no done pulse; a new start then runs the full sequence.
6. DIM=4, k_len=31 → feed_en for exactly 31 cycles (5-35); counter never wraps; done at cycle 43.
